idu: RTL and testbench

- Decode stage of the 5-stage RV64I pipeline, directly downstream of instruction fetch; consumes the IF/ID register (ifu_pc, ifu_instr, ifu_snxt_pc).
- Holds the 32x64 integer register file with its single write-back port.
- Generates immediates and control fields, and detects load-use hazards, driving ld_hz_stop back to fetch.
- Registers everything into the ID/EX pipeline register, inserting bubbles on stall or flush.

---
 rtl/idu_pkg.sv | 82 ++++++++
 rtl/regfile_2r1w.sv | 32 +++
 rtl/idu.sv | 197 +++++++++++++++++++
 tb/tb_idu.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/idu_pkg.sv
// rtl/idu_pkg.sv - shared constants, ID/EX record and ALU decode helper for the decode stage
package idu_pkg;

  localparam int XLEN_P = 64;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMMW = 7'b0011011;
  localparam logic [6:0] OPC_OPW    = 7'b0111011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [1:0] OP1_RS1  = 2'd0;
  localparam logic [1:0] OP1_PC   = 2'd1;
  localparam logic [1:0] OP1_ZERO = 2'd2;
  localparam logic       OP2_RS2  = 1'b0;
  localparam logic       OP2_IMM  = 1'b1;

  localparam logic [1:0] MEM_B = 2'd0;
  localparam logic [1:0] MEM_H = 2'd1;
  localparam logic [1:0] MEM_W = 2'd2;
  localparam logic [1:0] MEM_D = 2'd3;

  typedef struct packed {
    logic [XLEN_P-1:0] pc;
    logic [XLEN_P-1:0] snxt_pc;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [XLEN_P-1:0] rs1_data;
    logic [XLEN_P-1:0] rs2_data;
    logic [XLEN_P-1:0] imm;
    logic [3:0]        alu_op;
    logic              alu_word;
    logic [1:0]        op1_sel;
    logic              op2_sel;
    logic              rd_wen;
    logic              mem_ren;
    logic              mem_wen;
    logic [1:0]        mem_size;
    logic              mem_unsigned;
    logic              jump;
    logic              jalr;
    logic              branch;
    logic [2:0]        funct3;
    logic              ebreak;
    logic              illegal;
  } idex_t;

  // SUB only exists in register-register forms; ADDI never subtracts.
  function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic b30,
                                            input logic is_reg);
    case (f3)
      3'b000:  return (is_reg && b30) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return b30 ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// rtl/regfile_2r1w.sv - 32x64 integer register file, two bypassed read ports, one write port
module regfile_2r1w
  import idu_pkg::*;
(
  input  logic              clk,
  input  logic              i_wen,
  input  logic [4:0]        i_wa,
  input  logic [XLEN_P-1:0] i_wd,
  input  logic [4:0]        i_ra1,
  input  logic [4:0]        i_ra2,
  output logic [XLEN_P-1:0] o_rd1,
  output logic [XLEN_P-1:0] o_rd2
);

  logic [XLEN_P-1:0] r_mem [32];
  logic              w_wr;

  assign w_wr = i_wen && (i_wa != 5'd0);

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[i_wa] <= i_wd;
  end

  // x0 is never written, so it is forced to zero on read instead of being reset.
  always_comb begin
    o_rd1 = '0;
    o_rd2 = '0;
    if (i_ra1 != 5'd0) o_rd1 = (w_wr && i_wa == i_ra1) ? i_wd : r_mem[i_ra1];
    if (i_ra2 != 5'd0) o_rd2 = (w_wr && i_wa == i_ra2) ? i_wd : r_mem[i_ra2];
  end

endmodule

// File: rtl/idu.sv
// rtl/idu.sv - RV64I decode stage: decode, register read, load-use detection, ID/EX register
module idu
  import idu_pkg::*;
#(
  parameter int              XLEN           = 64,
  parameter logic [XLEN-1:0] RESET_PC_FIELD = 64'h0
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [XLEN-1:0] ifu_pc,
  input  logic [31:0]     ifu_instr,
  input  logic [XLEN-1:0] ifu_snxt_pc,
  input  logic            flush,
  input  logic            wb_wen,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            ld_hz_stop,
  output logic [XLEN-1:0] idu_pc,
  output logic [XLEN-1:0] idu_snxt_pc,
  output logic [4:0]      idu_rs1,
  output logic [4:0]      idu_rs2,
  output logic [4:0]      idu_rd,
  output logic [XLEN-1:0] idu_rs1_data,
  output logic [XLEN-1:0] idu_rs2_data,
  output logic [XLEN-1:0] idu_imm,
  output logic [3:0]      idu_alu_op,
  output logic            idu_alu_word,
  output logic [1:0]      idu_op1_sel,
  output logic            idu_op2_sel,
  output logic            idu_rd_wen,
  output logic            idu_mem_ren,
  output logic            idu_mem_wen,
  output logic [1:0]      idu_mem_size,
  output logic            idu_mem_unsigned,
  output logic            idu_jump,
  output logic            idu_jalr,
  output logic            idu_branch,
  output logic [2:0]      idu_funct3,
  output logic            idu_ebreak,
  output logic            idu_illegal
);

  idex_t             r_idex;
  idex_t             w_dec;
  idex_t             w_bub;
  logic [XLEN-1:0]   w_rs1_data, w_rs2_data;
  logic [XLEN-1:0]   w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic              w_rs1_used, w_rs2_used, w_shift;
  logic [6:0]        w_opc;
  logic [2:0]        w_f3;

  assign w_opc   = ifu_instr[6:0];
  assign w_f3    = ifu_instr[14:12];
  assign w_shift = (w_f3 == 3'b001) || (w_f3 == 3'b101);
  assign w_imm_i = {{52{ifu_instr[31]}}, ifu_instr[31:20]};
  assign w_imm_s = {{52{ifu_instr[31]}}, ifu_instr[31:25], ifu_instr[11:7]};
  assign w_imm_b = {{52{ifu_instr[31]}}, ifu_instr[7], ifu_instr[30:25], ifu_instr[11:8], 1'b0};
  assign w_imm_u = {{32{ifu_instr[31]}}, ifu_instr[31:12], 12'b0};
  assign w_imm_j = {{44{ifu_instr[31]}}, ifu_instr[19:12], ifu_instr[20], ifu_instr[30:21], 1'b0};

  regfile_2r1w u_rf (
    .clk   (clk),
    .i_wen (wb_wen),
    .i_wa  (wb_rd),
    .i_wd  (wb_data),
    .i_ra1 (ifu_instr[19:15]),
    .i_ra2 (ifu_instr[24:20]),
    .o_rd1 (w_rs1_data),
    .o_rd2 (w_rs2_data)
  );

  always_comb begin
    w_dec          = '0;
    w_rs1_used     = 1'b1;
    w_rs2_used     = 1'b0;
    w_dec.pc       = ifu_pc;
    w_dec.snxt_pc  = ifu_snxt_pc;
    w_dec.rs1      = ifu_instr[19:15];
    w_dec.rs2      = ifu_instr[24:20];
    w_dec.rs1_data = w_rs1_data;
    w_dec.rs2_data = w_rs2_data;
    w_dec.funct3   = w_f3;
    case (w_opc)
      OPC_LUI, OPC_AUIPC: begin
        w_rs1_used    = 1'b0;
        w_dec.rd_wen  = 1'b1;
        w_dec.op1_sel = (w_opc == OPC_LUI) ? OP1_ZERO : OP1_PC;
        w_dec.op2_sel = OP2_IMM;
        w_dec.imm     = w_imm_u;
      end
      OPC_JAL: begin
        w_rs1_used    = 1'b0;
        w_dec.rd_wen  = 1'b1;
        w_dec.jump    = 1'b1;
        w_dec.op1_sel = OP1_PC;
        w_dec.op2_sel = OP2_IMM;
        w_dec.imm     = w_imm_j;
      end
      OPC_JALR: begin
        w_dec.rd_wen  = 1'b1;
        w_dec.jump    = 1'b1;
        w_dec.jalr    = 1'b1;
        w_dec.op2_sel = OP2_IMM;
        w_dec.imm     = w_imm_i;
      end
      OPC_BRANCH: begin
        w_rs2_used   = 1'b1;
        w_dec.branch = 1'b1;
        w_dec.imm    = w_imm_b;
      end
      OPC_LOAD: begin
        w_dec.rd_wen       = 1'b1;
        w_dec.mem_ren      = 1'b1;
        w_dec.mem_size     = w_f3[1:0];
        w_dec.mem_unsigned = w_f3[2];
        w_dec.op2_sel      = OP2_IMM;
        w_dec.imm          = w_imm_i;
      end
      OPC_STORE: begin
        w_rs2_used     = 1'b1;
        w_dec.mem_wen  = 1'b1;
        w_dec.mem_size = w_f3[1:0];
        w_dec.op2_sel  = OP2_IMM;
        w_dec.imm      = w_imm_s;
      end
      OPC_OPIMM, OPC_OPIMMW: begin
        w_dec.rd_wen   = 1'b1;
        w_dec.alu_word = (w_opc == OPC_OPIMMW);
        w_dec.op2_sel  = OP2_IMM;
        w_dec.alu_op   = alu_decode(w_f3, ifu_instr[30], 1'b0);
        // Shift immediates carry only the shamt; the funct6/funct7 bits are stripped.
        if (!w_shift)                w_dec.imm = w_imm_i;
        else if (w_opc == OPC_OPIMM) w_dec.imm = {58'b0, ifu_instr[25:20]};
        else                         w_dec.imm = {59'b0, ifu_instr[24:20]};
      end
      OPC_OP, OPC_OPW: begin
        w_rs2_used     = 1'b1;
        w_dec.rd_wen   = 1'b1;
        w_dec.alu_word = (w_opc == OPC_OPW);
        w_dec.alu_op   = alu_decode(w_f3, ifu_instr[30], 1'b1);
      end
      OPC_SYSTEM: w_dec.ebreak = (ifu_instr == 32'h0010_0073);
      default: begin
        w_rs1_used    = 1'b0;
        w_dec.illegal = 1'b1;
      end
    endcase
    w_dec.rd = w_dec.rd_wen ? ifu_instr[11:7] : 5'd0;
  end

  assign ld_hz_stop = r_idex.mem_ren && (r_idex.rd != 5'd0) &&
                      ((w_rs1_used && w_dec.rs1 == r_idex.rd) ||
                       (w_rs2_used && w_dec.rs2 == r_idex.rd));

  always_comb begin
    w_bub         = '0;
    w_bub.pc      = ifu_pc;
    w_bub.snxt_pc = ifu_snxt_pc;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_idex         <= '0;
      r_idex.pc      <= RESET_PC_FIELD;
      r_idex.snxt_pc <= RESET_PC_FIELD;
    end else if (flush || ld_hz_stop) begin
      r_idex <= w_bub;
    end else begin
      r_idex <= w_dec;
    end
  end

  assign idu_pc           = r_idex.pc;
  assign idu_snxt_pc      = r_idex.snxt_pc;
  assign idu_rs1          = r_idex.rs1;
  assign idu_rs2          = r_idex.rs2;
  assign idu_rd           = r_idex.rd;
  assign idu_rs1_data     = r_idex.rs1_data;
  assign idu_rs2_data     = r_idex.rs2_data;
  assign idu_imm          = r_idex.imm;
  assign idu_alu_op       = r_idex.alu_op;
  assign idu_alu_word     = r_idex.alu_word;
  assign idu_op1_sel      = r_idex.op1_sel;
  assign idu_op2_sel      = r_idex.op2_sel;
  assign idu_rd_wen       = r_idex.rd_wen;
  assign idu_mem_ren      = r_idex.mem_ren;
  assign idu_mem_wen      = r_idex.mem_wen;
  assign idu_mem_size     = r_idex.mem_size;
  assign idu_mem_unsigned = r_idex.mem_unsigned;
  assign idu_jump         = r_idex.jump;
  assign idu_jalr         = r_idex.jalr;
  assign idu_branch       = r_idex.branch;
  assign idu_funct3       = r_idex.funct3;
  assign idu_ebreak       = r_idex.ebreak;
  assign idu_illegal      = r_idex.illegal;

endmodule

// File: tb/tb_idu.sv
// tb/tb_idu.sv - directed table-driven bench for the idu decode stage
module tb_idu;

  localparam logic [7:0] F_WEN = 8'h01, F_REN = 8'h02, F_MWEN = 8'h04, F_JMP = 8'h08;
  localparam logic [7:0] F_JALR = 8'h10, F_BR = 8'h20, F_EBRK = 8'h40, F_ILL = 8'h80;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [63:0] ifu_pc = '0, ifu_snxt_pc = '0, wb_data = '0;
  logic [31:0] ifu_instr = 32'h13;
  logic        flush = 1'b0, wb_wen = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic        ld_hz_stop;
  logic [63:0] idu_pc, idu_snxt_pc, idu_rs1_data, idu_rs2_data, idu_imm;
  logic [4:0]  idu_rs1, idu_rs2, idu_rd;
  logic [3:0]  idu_alu_op;
  logic [1:0]  idu_op1_sel, idu_mem_size;
  logic [2:0]  idu_funct3;
  logic        idu_alu_word, idu_op2_sel, idu_rd_wen, idu_mem_ren, idu_mem_wen;
  logic        idu_mem_unsigned, idu_jump, idu_jalr, idu_branch, idu_ebreak, idu_illegal;

  idu dut (
    .clk(clk), .rstn(rstn), .ifu_pc(ifu_pc), .ifu_instr(ifu_instr), .ifu_snxt_pc(ifu_snxt_pc),
    .flush(flush), .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data), .ld_hz_stop(ld_hz_stop),
    .idu_pc(idu_pc), .idu_snxt_pc(idu_snxt_pc), .idu_rs1(idu_rs1), .idu_rs2(idu_rs2),
    .idu_rd(idu_rd), .idu_rs1_data(idu_rs1_data), .idu_rs2_data(idu_rs2_data), .idu_imm(idu_imm),
    .idu_alu_op(idu_alu_op), .idu_alu_word(idu_alu_word), .idu_op1_sel(idu_op1_sel),
    .idu_op2_sel(idu_op2_sel), .idu_rd_wen(idu_rd_wen), .idu_mem_ren(idu_mem_ren),
    .idu_mem_wen(idu_mem_wen), .idu_mem_size(idu_mem_size), .idu_mem_unsigned(idu_mem_unsigned),
    .idu_jump(idu_jump), .idu_jalr(idu_jalr), .idu_branch(idu_branch), .idu_funct3(idu_funct3),
    .idu_ebreak(idu_ebreak), .idu_illegal(idu_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [63:0] imm;
    logic [7:0]  flags;
    logic [10:0] sel;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;
  vec_t tbl[18];

  function automatic vec_t mk(logic [31:0] instr, logic [4:0] rd, logic [63:0] imm,
                              logic [7:0] flags, logic word, logic [1:0] op1, logic op2,
                              logic [3:0] alu, logic [1:0] size, logic uns);
    vec_t v;
    v.instr = instr; v.rd = rd; v.imm = imm; v.flags = flags;
    v.sel = {word, op1, op2, alu, size, uns};
    return v;
  endfunction

  function automatic logic [7:0] dut_flags();
    return {idu_illegal, idu_ebreak, idu_branch, idu_jalr, idu_jump,
            idu_mem_wen, idu_mem_ren, idu_rd_wen};
  endfunction

  function automatic logic [10:0] dut_sel();
    return {idu_alu_word, idu_op1_sel, idu_op2_sel, idu_alu_op, idu_mem_size, idu_mem_unsigned};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] instr, input logic [63:0] pc);
    @(negedge clk);
    ifu_instr   = instr;
    ifu_pc      = pc;
    ifu_snxt_pc = pc + 64'd4;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ALU codes: ADD0 SUB1 SLL2 SLT3 SLTU4 XOR5 SRL6 SRA7 OR8 AND9; op1 0=rs1 1=pc 2=zero
    tbl[0]  = mk(32'h0070_0293, 5'd5,  64'd7,                  F_WEN,  0, 2'd0, 1, 4'd0, 2'd0, 0);
    tbl[1]  = mk(32'h1234_53B7, 5'd7,  64'h0000_0000_1234_5000, F_WEN,  0, 2'd2, 1, 4'd0, 2'd0, 0);
    tbl[2]  = mk(32'h8020_8063, 5'd0,  64'hFFFF_FFFF_FFFF_F000, F_BR,   0, 2'd0, 0, 4'd0, 2'd0, 0);
    tbl[3]  = mk(32'h7FFF_F0EF, 5'd1,  64'h0000_0000_000F_FFFE, F_WEN | F_JMP, 0, 2'd1, 1, 4'd0, 2'd0, 0);
    tbl[4]  = mk(32'hFFFF_F0EF, 5'd1,  64'hFFFF_FFFF_FFFF_FFFE, F_WEN | F_JMP, 0, 2'd1, 1, 4'd0, 2'd0, 0);
    tbl[5]  = mk(32'h41F4_D41B, 5'd8,  64'd31,                 F_WEN,  1, 2'd0, 1, 4'd7, 2'd0, 0);
    tbl[6]  = mk(32'h43F5_D513, 5'd10, 64'd63,                 F_WEN,  0, 2'd0, 1, 4'd7, 2'd0, 0);
    tbl[7]  = mk(32'h4031_00B3, 5'd1,  64'd0,                  F_WEN,  0, 2'd0, 0, 4'd1, 2'd0, 0);
    tbl[8]  = mk(32'h0001_3303, 5'd6,  64'd0,                  F_WEN | F_REN, 0, 2'd0, 1, 4'd0, 2'd3, 0);
    tbl[9]  = mk(32'h1234_53B7, 5'd7,  64'h0000_0000_1234_5000, F_WEN,  0, 2'd2, 1, 4'd0, 2'd0, 0);
    tbl[10] = mk(32'hFE52_2C23, 5'd0,  64'hFFFF_FFFF_FFFF_FFF8, F_MWEN, 0, 2'd0, 1, 4'd0, 2'd2, 0);
    tbl[11] = mk(32'hFFFF_FFFF, 5'd0,  64'd0,                  F_ILL,  0, 2'd0, 0, 4'd0, 2'd0, 0);
    tbl[12] = mk(32'h0010_0073, 5'd0,  64'd0,                  F_EBRK, 0, 2'd0, 0, 4'd0, 2'd0, 0);
    tbl[13] = mk(32'h0000_1197, 5'd3,  64'h1000,               F_WEN,  0, 2'd1, 1, 4'd0, 2'd0, 0);
    tbl[14] = mk(32'hFFF0_C483, 5'd9,  64'hFFFF_FFFF_FFFF_FFFF, F_WEN | F_REN, 0, 2'd0, 1, 4'd0, 2'd0, 1);
    tbl[15] = mk(32'h0042_80E7, 5'd1,  64'd4,                  F_WEN | F_JMP | F_JALR, 0, 2'd0, 1, 4'd0, 2'd0, 0);
    tbl[16] = mk(32'h0041_813B, 5'd2,  64'd0,                  F_WEN,  1, 2'd0, 0, 4'd0, 2'd0, 0);
    tbl[17] = mk(32'h0000_0013, 5'd0,  64'd0,                  F_WEN,  0, 2'd0, 1, 4'd0, 2'd0, 0);

    drive(32'h0070_0293, 64'h1234);
    tick();
    tick();
    chk("reset_pc", idu_pc, 64'h0);
    chk("reset_snxt", idu_snxt_pc, 64'h0);
    chk("reset_flags", {56'd0, dut_flags()}, 64'h0);
    chk("reset_imm", idu_imm, 64'h0);
    chk("reset_rd", {59'd0, idu_rd}, 64'h0);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].instr, 64'h8000_0000 + 64'(i) * 4);
      chk($sformatf("v%0d_hz", i), {63'd0, ld_hz_stop}, 64'h0);
      tick();
      chk($sformatf("v%0d_flags", i), {56'd0, dut_flags()}, {56'd0, tbl[i].flags});
      chk($sformatf("v%0d_sel", i), {53'd0, dut_sel()}, {53'd0, tbl[i].sel});
      chk($sformatf("v%0d_rd", i), {59'd0, idu_rd}, {59'd0, tbl[i].rd});
      chk($sformatf("v%0d_imm", i), idu_imm, tbl[i].imm);
      chk($sformatf("v%0d_pc", i), idu_pc, 64'h8000_0000 + 64'(i) * 4);
    end
    chk("snxt_last", idu_snxt_pc, 64'h8000_0000 + 17 * 4 + 4);

    // write-back bypass into ADD x1,x3,x3 and x0 write suppression
    drive(32'h0031_80B3, 64'h100);
    wb_wen = 1'b1; wb_rd = 5'd3; wb_data = 64'hDEAD;
    tick();
    chk("byp_rs1", idu_rs1_data, 64'hDEAD);
    chk("byp_rs2", idu_rs2_data, 64'hDEAD);
    drive(32'h0000_00B3, 64'h104);
    wb_wen = 1'b1; wb_rd = 5'd0; wb_data = 64'h55;
    tick();
    chk("x0_bypass", idu_rs1_data, 64'h0);
    drive(32'h0030_00B3, 64'h108);
    wb_wen = 1'b0;
    tick();
    chk("x0_stored", idu_rs1_data, 64'h0);
    chk("x3_stored", idu_rs2_data, 64'hDEAD);

    // load-use: LD x6 then ADD x7,x6,x1
    drive(32'h0001_3303, 64'h200);
    tick();
    drive(32'h0013_03B3, 64'h204);
    chk("lu_hz_on", {63'd0, ld_hz_stop}, 64'h1);
    tick();
    chk("lu_bub_flags", {56'd0, dut_flags()}, 64'h0);
    chk("lu_bub_rd", {59'd0, idu_rd}, 64'h0);
    chk("lu_hz_off", {63'd0, ld_hz_stop}, 64'h0);
    tick();
    chk("lu_add_rd", {59'd0, idu_rd}, 64'd7);
    chk("lu_add_flags", {56'd0, dut_flags()}, {56'd0, F_WEN});
    chk("lu_add_pc", idu_pc, 64'h204);

    // flush and hazard in the same cycle
    drive(32'h0001_3303, 64'h300);
    tick();
    drive(32'h0013_03B3, 64'h304);
    flush = 1'b1;
    chk("fl_hz_on", {63'd0, ld_hz_stop}, 64'h1);
    tick();
    chk("fl_mem_ren", {63'd0, idu_mem_ren}, 64'h0);
    chk("fl_rd", {59'd0, idu_rd}, 64'h0);
    chk("fl_flags", {56'd0, dut_flags()}, 64'h0);
    chk("fl_pc", idu_pc, 64'h304);
    @(negedge clk);
    flush = 1'b0;

    // plain flush kills a normal instruction
    drive(32'h0070_0293, 64'h400);
    flush = 1'b1;
    tick();
    chk("fl2_flags", {56'd0, dut_flags()}, 64'h0);
    @(negedge clk);
    flush = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
